// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line parameters, bit-timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int UART_AXI_DATA_WIDTH = 32;
  localparam int UART_CLOCK          = 100_000_000;
  localparam int UART_BAUD_RATE      = 115200;
  localparam int UART_DATA_BITS      = 8;
  localparam int UART_STOP_BITS      = 1;
  localparam int UART_PARITY_BITS    = 0;

  function automatic int clks_per_bit(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream data channel (tdata/tvalid/tready) with source and sink views.
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter with a one-cycle strobe at mid-bit; held at zero while clear is high.
// The strobe lands CLKS_PER_BIT/2 cycles after clear drops, then once per bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  output logic mid_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mid_tick = !clear && (cnt == MID);

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver packing characters LSB-first into AXI-Stream words; output is a single holding register.
// A word completing while the held word is stalled is dropped (rx_overrun); a same-cycle handshake frees the slot.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = UART_AXI_DATA_WIDTH,
  parameter int CLOCK          = UART_CLOCK,
  parameter int BAUD_RATE      = UART_BAUD_RATE,
  parameter int DATA_BITS      = UART_DATA_BITS,
  parameter int STOP_BITS      = UART_STOP_BITS,
  parameter int PARITY_BITS    = UART_PARITY_BITS
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rx,
  axis_if.master     m_axis,
  output logic       rx_done,
  output logic [1:0] rx_error,
  output logic       rx_overrun
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK, BAUD_RATE);
  localparam int NCHARS       = AXI_DATA_WIDTH / DATA_BITS;
  localparam int IW           = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHARS - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state, next_state;

  logic                      rx_meta, rx_s, rx_prev, fall;
  logic                      tick, baud_clear;
  logic                      data_sample, par_sample, stop_sample, last_stop;
  logic [2:0]                bit_cnt;
  logic [DATA_BITS-1:0]      shift;
  logic                      par_bit, stop_bad;
  logic                      exp_par, par_err, frame_err, char_ok, char_bad, word_done;
  logic [IW-1:0]             char_idx;
  logic [AXI_DATA_WIDTH-1:0] word_buf, word_next, tdata_q;
  logic                      tvalid_q;

  // rx_prev keeps the previous synchronized sample for falling-edge detection.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clear    (baud_clear),
    .mid_tick (tick)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (fall) next_state = START;
      START:   if (tick) next_state = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == LAST_DATA) next_state = PARITY;
      PARITY:  if (tick) next_state = STOP;
      STOP:    if (tick && bit_cnt == LAST_STOP) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    baud_clear  = (state == IDLE);
    data_sample = (state == DATA) && tick;
    par_sample  = (state == PARITY) && tick;
    stop_sample = (state == STOP) && tick;
    last_stop   = stop_sample && (bit_cnt == LAST_STOP);
  end

  // Character verdict is formed in the final stop-sample cycle using the live stop sample.
  assign exp_par   = (PARITY_BITS == 0) ? ~^shift : ^shift;
  assign par_err   = (par_bit != exp_par);
  assign frame_err = stop_bad | ~rx_s;
  assign char_ok   = last_stop & ~par_err & ~frame_err;
  assign char_bad  = last_stop & (par_err | frame_err);
  assign word_done = char_ok & (char_idx == LAST_IDX);

  always_comb begin
    word_next = word_buf;
    word_next[char_idx*DATA_BITS +: DATA_BITS] = shift;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_bad <= 1'b0;
      word_buf <= '0;
      char_idx <= '0;
    end else begin
      if (state != next_state)            bit_cnt <= '0;
      else if (data_sample || stop_sample) bit_cnt <= bit_cnt + 1'b1;
      if (data_sample) shift <= {rx_s, shift[DATA_BITS-1:1]};
      if (par_sample) begin
        par_bit  <= rx_s;
        stop_bad <= 1'b0;
      end
      if (stop_sample && !rx_s) stop_bad <= 1'b1;
      if (char_ok) begin
        word_buf <= word_next;
        char_idx <= word_done ? '0 : char_idx + 1'b1;
      end else if (char_bad) begin
        char_idx <= '0;
      end
    end
  end

  // Holding register: a handshake in the completion cycle counts as accept-then-load.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      rx_done    <= 1'b0;
      rx_error   <= 2'b00;
      rx_overrun <= 1'b0;
    end else begin
      rx_done    <= 1'b0;
      rx_overrun <= 1'b0;
      rx_error   <= last_stop ? {frame_err, par_err} : 2'b00;
      if (word_done && (!tvalid_q || m_axis.tready)) begin
        tdata_q  <= word_next;
        tvalid_q <= 1'b1;
        rx_done  <= 1'b1;
      end else begin
        if (word_done)                   rx_overrun <= 1'b1;
        if (tvalid_q && m_axis.tready)   tvalid_q   <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;

endmodule
